// File: rtl/req_esc_pkg.sv
// req_esc_pkg: shared types and constants for the priority-escalation
// request/acknowledge controller.
//   state_t : sweep FSM states (IDLE, REQ, WAIT, DONE)
//   CNT_W   : width of the pass/fail statistics counters
//   CNT_MAX : saturation value of the statistics counters
//   WIN_W   : width of the ack window counter (ACK_WIN up to 15)
package req_esc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int              WIN_W   = 4;

endpackage

// File: rtl/req_esc_trig.sv
// req_esc_trig: two-phase sweep trigger. Registers `ready` every cycle and
// raises `start` when `go` follows `ready` by one cycle while the controller
// is idle. Triggers seen while not idle are dropped, not queued.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ready    : trigger phase 1
//   go       : trigger phase 2 (cycle after ready)
//   idle     : controller is in IDLE
//   start    : combinational start pulse
module req_esc_trig (
    input  logic clk,
    input  logic rst,
    input  logic ready,
    input  logic go,
    input  logic idle,
    output logic start
);

    logic ready_q;

    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ready;
    end

    assign start = ready_q && go && idle;

endmodule

// File: rtl/req_escalator.sv
// req_escalator: priority-escalation request/acknowledge controller.
// A ready-then-go trigger starts a sweep: req is driven for one cycle on
// lane 0, then ack on that lane is accepted for ACK_WIN cycles. Without an
// ack the sweep moves to the next lane, failing after lane NLVL-1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   ready, go : two-phase trigger
//   ack       : per-lane acknowledge (only the active lane is looked at)
//   req       : per-lane request, one-hot or zero
//   busy      : sweep in progress (REQ/WAIT/DONE)
//   done      : one-cycle completion pulse, pass valid with it
//   level     : lane being requested; holds the final lane after done
//   t         : sticky result, cleared at sweep start, set on pass
//   pass_cnt, fail_cnt : saturating statistics
// Optional feature: define REQ_ESCALATOR_STATS_EN to build the pass/fail
// counters; otherwise both outputs are tied to zero.
module req_escalator
    import req_esc_pkg::*;
#(
    parameter  int NLVL    = 4,
    parameter  int ACK_WIN = 1,
    localparam int LW      = (NLVL > 1) ? $clog2(NLVL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic             go,
    input  logic [NLVL-1:0]  ack,
    output logic [NLVL-1:0]  req,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LW-1:0]    level,
    output logic             t,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    state_t           state, state_nxt;
    logic [LW-1:0]    lvl_q;
    logic [WIN_W-1:0] win_cnt;
    logic             pass_q;
    logic             t_q;
    logic             start;
    logic             ack_hit;
    logic             win_last;
    logic             at_top;

    req_esc_trig u_trig (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .go    (go),
        .idle  (state == IDLE),
        .start (start)
    );

    assign ack_hit  = ack[lvl_q];
    // Counter is loaded with ACK_WIN, so the value 1 marks the last
    // cycle of the window.
    assign win_last = (win_cnt == WIN_W'(1));
    assign at_top   = (lvl_q == LW'(NLVL - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (ack_hit)       state_nxt = DONE;
                else if (win_last) state_nxt = at_top ? DONE : REQ;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane, window and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= '0;
            win_cnt <= '0;
            pass_q  <= 1'b0;
            t_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lvl_q <= '0;
                        t_q   <= 1'b0;
                    end
                end
                REQ: win_cnt <= WIN_W'(ACK_WIN);
                WAIT: begin
                    if (ack_hit) begin
                        pass_q <= 1'b1;
                        t_q    <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                        if (win_last) begin
                            // No wrap: the top lane ends the sweep as a fail.
                            if (at_top) pass_q <= 1'b0;
                            else        lvl_q  <= lvl_q + LW'(1);
                        end
                    end
                end
                DONE: pass_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req  = '0;
        if (state == REQ) req[lvl_q] = 1'b1;
        busy = (state != IDLE);
        done = (state == DONE);
        pass = (state == DONE) && pass_q;
    end

    assign level = lvl_q;
    assign t     = t_q;

`ifdef REQ_ESCALATOR_STATS_EN
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] fail_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (done) begin
            if (pass && pass_cnt_q != CNT_MAX)  pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            if (!pass && fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_req_escalator.sv
// tb_req_escalator: drives two controllers (ACK_WIN=1 and ACK_WIN=3) with the
// same directed and random stimulus and compares every output each cycle with
// a sweep model expressed as a position count within the sweep.
module tb_req_escalator;

    localparam int NLVL = 4;
    localparam int LW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ready;
    logic            go;
    logic [NLVL-1:0] ack;

    logic [NLVL-1:0] d_req   [2];
    logic            d_busy  [2];
    logic            d_done  [2];
    logic            d_pass  [2];
    logic [LW-1:0]   d_level [2];
    logic            d_t     [2];
    logic [15:0]     d_pcnt  [2];
    logic [15:0]     d_fcnt  [2];

    int n_vec = 0;
    int n_err = 0;

    // model state per instance
    int win     [2] = '{1, 3};
    bit m_act   [2];
    bit m_done  [2];
    bit m_pass  [2];
    bit m_t     [2];
    bit m_rq    [2];
    int m_pos   [2];
    int m_lvl   [2];
    int m_pc    [2];
    int m_fc    [2];

    always #5 clk = ~clk;

    req_escalator #(.NLVL(NLVL), .ACK_WIN(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready), .go(go), .ack(ack),
        .req(d_req[0]), .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
        .level(d_level[0]), .t(d_t[0]), .pass_cnt(d_pcnt[0]), .fail_cnt(d_fcnt[0])
    );

    req_escalator #(.NLVL(NLVL), .ACK_WIN(3)) dut3 (
        .clk(clk), .rst(rst), .ready(ready), .go(go), .ack(ack),
        .req(d_req[1]), .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
        .level(d_level[1]), .t(d_t[1]), .pass_cnt(d_pcnt[1]), .fail_cnt(d_fcnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_t[k] = 0;
            m_rq[k] = 0; m_pos[k] = 0; m_lvl[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [NLVL-1:0] ereq;
            bit ebusy, edone, epass;
            int elvl, lane, off;
            ereq = '0; ebusy = 0; edone = 0; epass = 0; elvl = m_lvl[k];
            if (m_act[k]) begin
                lane = m_pos[k] / (win[k] + 1);
                off  = m_pos[k] % (win[k] + 1);
                if (off == 0) ereq[lane] = 1'b1;
                ebusy = 1; elvl = lane;
            end else if (m_done[k]) begin
                ebusy = 1; edone = 1; epass = m_pass[k];
            end
            chk($sformatf("req[w%0d]", win[k]),   32'(d_req[k]),   32'(ereq));
            chk($sformatf("busy[w%0d]", win[k]),  32'(d_busy[k]),  32'(ebusy));
            chk($sformatf("done[w%0d]", win[k]),  32'(d_done[k]),  32'(edone));
            chk($sformatf("pass[w%0d]", win[k]),  32'(d_pass[k]),  32'(epass));
            chk($sformatf("level[w%0d]", win[k]), 32'(d_level[k]), 32'(elvl));
            chk($sformatf("t[w%0d]", win[k]),     32'(d_t[k]),     32'(m_t[k]));
`ifdef REQ_ESCALATOR_STATS_EN
            chk($sformatf("pcnt[w%0d]", win[k]),  32'(d_pcnt[k]),  32'(m_pc[k]));
            chk($sformatf("fcnt[w%0d]", win[k]),  32'(d_fcnt[k]),  32'(m_fc[k]));
`else
            chk($sformatf("pcnt[w%0d]", win[k]),  32'(d_pcnt[k]),  32'd0);
            chk($sformatf("fcnt[w%0d]", win[k]),  32'(d_fcnt[k]),  32'd0);
`endif
        end
    endtask

    // Advance the model over one clock edge with the applied inputs.
    task automatic model_upd();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_t[k] = 0;
                m_rq[k] = 0; m_pos[k] = 0; m_lvl[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
            end else begin
                bit st;
                int lane, off;
                st = m_rq[k] && go && !m_act[k] && !m_done[k];
                if (m_done[k]) begin
                    if (m_pass[k]) m_pc[k] = (m_pc[k] == 16'hFFFF) ? m_pc[k] : m_pc[k] + 1;
                    else           m_fc[k] = (m_fc[k] == 16'hFFFF) ? m_fc[k] : m_fc[k] + 1;
                    m_done[k] = 0; m_pass[k] = 0;
                end else if (m_act[k]) begin
                    lane = m_pos[k] / (win[k] + 1);
                    off  = m_pos[k] % (win[k] + 1);
                    if (off > 0 && ack[lane]) begin
                        m_act[k] = 0; m_done[k] = 1; m_pass[k] = 1; m_t[k] = 1; m_lvl[k] = lane;
                    end else if (off == win[k] && lane == NLVL - 1) begin
                        m_act[k] = 0; m_done[k] = 1; m_pass[k] = 0; m_lvl[k] = lane;
                    end else begin
                        m_pos[k]++;
                    end
                end else if (st) begin
                    m_act[k] = 1; m_pos[k] = 0; m_t[k] = 0; m_lvl[k] = 0;
                end
                m_rq[k] = ready;
            end
        end
    endtask

    // One cycle: apply inputs, check at negedge, update model at the edge.
    task automatic cyc(input bit r, input bit rd, input bit g, input logic [NLVL-1:0] a);
        rst = r; ready = rd; go = g; ack = a;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; go = 1'b0; ack = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // c0 ready, c1 go, ack[0] at c3 -> pass on lane 0 at c4
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0); cyc(0, 0, 0, '0); cyc(0, 0, 0, 4'b0001);
        chk("tp1_done",  32'(d_done[0]),  32'd1);
        chk("tp1_pass",  32'(d_pass[0]),  32'd1);
        chk("tp1_t",     32'(d_t[0]),     32'd1);
        chk("tp1_level", 32'(d_level[0]), 32'd0);
        idle(6);

        // no acks: req on lanes 0..3 at c2,c4,c6,c8, fail at c10
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) chk("tp2_req", 32'(d_req[0]), 32'(1 << (i / 2)));
            cyc(0, 0, 0, '0);
        end
        chk("tp2_done",  32'(d_done[0]),  32'd1);
        chk("tp2_pass",  32'(d_pass[0]),  32'd0);
        chk("tp2_t",     32'(d_t[0]),     32'd0);
        chk("tp2_level", 32'(d_level[0]), 32'd3);
        idle(12);

        // ack[2] held from c0, ack[1] pulsed at c2 -> pass on lane 2 at c8
        cyc(0, 1, 0, 4'b0100); cyc(0, 0, 1, 4'b0100); cyc(0, 0, 0, 4'b0110);
        for (int i = 3; i < 8; i++) cyc(0, 0, 0, 4'b0100);
        chk("tp3_done",  32'(d_done[0]),  32'd1);
        chk("tp3_pass",  32'(d_pass[0]),  32'd1);
        chk("tp3_level", 32'(d_level[0]), 32'd2);
        idle(20);

        // ACK_WIN=3: ack[1] in third WAIT cycle of lane 1 (c9) -> pass lane 1
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0);
        for (int i = 2; i < 9; i++) cyc(0, 0, 0, '0);
        cyc(0, 0, 0, 4'b0010);
        chk("tp4_done",  32'(d_done[1]),  32'd1);
        chk("tp4_pass",  32'(d_pass[1]),  32'd1);
        chk("tp4_level", 32'(d_level[1]), 32'd1);
        idle(20);

        // same, but ack[1] one cycle late (c10) -> lane 2 requested at c10
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0);
        for (int i = 2; i < 10; i++) cyc(0, 0, 0, '0);
        chk("tp5_req", 32'(d_req[1]), 32'b0100);
        cyc(0, 0, 0, 4'b0010);
        chk("tp5_busy", 32'(d_busy[1]), 32'd1);
        idle(20);

        // rst the cycle after req[1] (c5) -> everything back to reset
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0);
        for (int i = 2; i < 5; i++) cyc(0, 0, 0, '0);
        cyc(1, 0, 0, '0);
        chk("tp6_busy", 32'(d_busy[0]), 32'd0);
        chk("tp6_done", 32'(d_done[0]), 32'd0);
        chk("tp6_req",  32'(d_req[0]),  32'd0);

        // go without ready, and trigger during a busy sweep
        cyc(0, 0, 1, '0);
        chk("tp7_nostart", 32'(d_busy[0]), 32'd0);
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0); cyc(0, 1, 0, '0); cyc(0, 0, 1, '0);
        idle(20);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [NLVL-1:0] a;
            a = NLVL'($urandom) & NLVL'($urandom) & NLVL'($urandom);
            if ($urandom_range(0, 7) == 0) a = '1;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, a);
        end

`ifdef REQ_ESCALATOR_STATS_EN
        // saturation: preload the pass counter and complete another pass
        idle(20);
        force dut1.pass_cnt_q = 16'hFFFF;
        #1;
        release dut1.pass_cnt_q;
        m_pc[0] = 16'hFFFF;
        cyc(0, 1, 0, '0); cyc(0, 0, 1, '0); cyc(0, 0, 0, '0); cyc(0, 0, 0, 4'b0001);
        idle(4);
        chk("sat_pcnt", 32'(d_pcnt[0]), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
